// File: rtl/systolic_feeder.sv
// systolic_feeder: operand store and skewed stream sequencer for an MxM systolic array.
//
// Holds operand matrices A and B and runs one multiply per start pulse:
// IDLE -> CLEAR (clear PE accumulators) -> FEED (3M-2 skewed steps) -> DONE -> IDLE.
// During FEED step k, row i of the array gets A[i][k-i] and column j gets B[k-j][j],
// or 0 where the index falls outside the matrix.
//
// Optional build macro: FEEDER_RUN_CNT_EN adds a 32-bit run_count output that counts
// completed runs (reset to 0, wraps).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_sel     operand write strobe; 0 = A, 1 = B (accepted only in IDLE)
//   wr_row, wr_col    element indices; indices >= M are dropped
//   wr_data           signed element value
//   start             begin a multiply (ignored while busy)
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle pulse when the array results are valid
//   arr_clr           accumulator clear to the array
//   arr_en            array enable, aligned with x_feed/y_feed
//   x_feed, y_feed    row and column operand streams
//   run_count         completed-run counter (FEEDER_RUN_CNT_EN only)
module systolic_feeder #(
  parameter int unsigned Q = 10,
  parameter int unsigned N = 32,
  parameter int unsigned M = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(M)-1:0]  wr_row,
  input  logic [$clog2(M)-1:0]  wr_col,
  input  logic signed [N-1:0]   wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  arr_clr,
  output logic                  arr_en,
  output logic signed [N-1:0]   x_feed [0:M-1],
  output logic signed [N-1:0]   y_feed [0:M-1]
`ifdef FEEDER_RUN_CNT_EN
  ,
  output logic [31:0]           run_count
`endif
);

  localparam int unsigned IW = $clog2(M);
  // k runs 0 .. 3M-3, so 3M-2 distinct values.
  localparam int unsigned KW = $clog2(3 * M - 2);
  localparam logic [KW-1:0] KLast = KW'(3 * M - 3);

  // Q only documents the fixed-point format shared with the array; data is passed
  // through untouched. A fraction as wide as the word is a configuration error.
  if (Q >= N) begin : g_bad_q_width
  end

  typedef enum logic [1:0] {StIdle, StClear, StFeed, StDone} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;

  logic signed [N-1:0] a_q [0:M-1][0:M-1];
  logic signed [N-1:0] b_q [0:M-1][0:M-1];

  logic                busy_d, done_d, clr_d, en_d;
  logic signed [N-1:0] x_d [0:M-1];
  logic signed [N-1:0] y_d [0:M-1];

  // Operand storage: not reset, written only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle) &&
        (int'(wr_row) < int'(M)) && (int'(wr_col) < int'(M))) begin
      if (wr_sel) b_q[wr_row][wr_col] <= wr_data;
      else        a_q[wr_row][wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StClear;
      StClear: begin
        state_d = StFeed;
        k_d     = '0;
      end
      StFeed: begin
        if (k_q == KLast) state_d = StDone;
        else              k_d     = k_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered, with the feeds
  // for step k landing in the same cycle as arr_en for that step.
  always_comb begin
    int d;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    clr_d  = (state_d == StClear);
    en_d   = (state_d == StFeed);
    d      = 0;
    for (int i = 0; i < int'(M); i++) begin
      x_d[i] = '0;
      y_d[i] = '0;
      if (en_d) begin
        d = int'(k_d) - i;
        if (d >= 0 && d < int'(M)) begin
          x_d[i] = a_q[i][IW'(d)];
          y_d[i] = b_q[IW'(d)][i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      arr_clr <= 1'b0;
      arr_en  <= 1'b0;
      for (int i = 0; i < int'(M); i++) begin
        x_feed[i] <= '0;
        y_feed[i] <= '0;
      end
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      arr_clr <= clr_d;
      arr_en  <= en_d;
      for (int i = 0; i < int'(M); i++) begin
        x_feed[i] <= x_d[i];
        y_feed[i] <= y_d[i];
      end
    end
  end

`ifdef FEEDER_RUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    run_count <= '0;
    else if (state_q == StDone) run_count <= run_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (M=6, N=32): reset state, run timing, skew,
// write blocking during a run, same-cycle start+write, reset mid-run.
module tb_systolic_feeder;
  localparam int unsigned Q  = 10;
  localparam int unsigned N  = 32;
  localparam int unsigned M  = 6;
  localparam int unsigned IW = $clog2(M);

  logic                 clk;
  logic                 rst;
  logic                 wr_en;
  logic                 wr_sel;
  logic [IW-1:0]        wr_row;
  logic [IW-1:0]        wr_col;
  logic signed [N-1:0]  wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 arr_clr;
  logic                 arr_en;
  logic signed [N-1:0]  x_feed [0:M-1];
  logic signed [N-1:0]  y_feed [0:M-1];
`ifdef FEEDER_RUN_CNT_EN
  logic [31:0]          run_count;
`endif

  systolic_feeder #(.Q(Q), .N(N), .M(M)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .arr_clr   (arr_clr),
    .arr_en    (arr_en),
    .x_feed    (x_feed),
    .y_feed    (y_feed)
`ifdef FEEDER_RUN_CNT_EN
    ,
    .run_count (run_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int am [0:M-1][0:M-1];
  int bm [0:M-1][0:M-1];
  int snap0 [0:M-1];
  int snap7 [0:M-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one write for a cycle; the model follows only in-range indices.
  task automatic write_elem(input bit sel, input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = IW'(row);
    wr_col  = IW'(col);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (row < int'(M) && col < int'(M)) begin
      if (sel) bm[row][col] = data;
      else     am[row][col] = data;
    end
  endtask

  // Pulse start (any write already set up by the caller rides along), then check every
  // output each cycle T+1 .. T+3M+2. inj pulses start and a write of 999 to A[0][0] at k=3.
  task automatic run(input bit inj, output int done_at, output int en_cnt, output int clr_cnt);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wr_en   = 1'b0;
    done_at = -1;
    en_cnt  = 0;
    clr_cnt = 0;
    for (int c = 1; c <= 3 * int'(M) + 2; c++) begin
      int k;
      bit en_exp;
      k      = c - 2;
      en_exp = (c >= 2) && (c <= 3 * int'(M) - 1);
      if (arr_en === 1'b1) en_cnt++;
      if (arr_clr === 1'b1) clr_cnt++;
      if (done === 1'b1 && done_at < 0) done_at = c;
      check($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 3 * int'(M)));
      check($sformatf("arr_clr c%0d", c), 32'(arr_clr), 32'(c == 1));
      check($sformatf("arr_en c%0d", c), 32'(arr_en), 32'(en_exp));
      check($sformatf("done c%0d", c), 32'(done), 32'(c == 3 * int'(M)));
      for (int i = 0; i < int'(M); i++) begin
        int d;
        int xe;
        int ye;
        d  = k - i;
        xe = 0;
        ye = 0;
        if (en_exp && d >= 0 && d < int'(M)) begin
          xe = am[i][d];
          ye = bm[d][i];
        end
        check($sformatf("x_feed[%0d] c%0d", i, c), x_feed[i], xe);
        check($sformatf("y_feed[%0d] c%0d", i, c), y_feed[i], ye);
        if (k == 0) snap0[i] = x_feed[i];
        if (k == 7) snap7[i] = x_feed[i];
      end
      start = 1'b0;
      wr_en = 1'b0;
      if (inj && k == 3) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = 999;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    int done_at;
    int en_cnt;
    int clr_cnt;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    start   = 1'b0;
    for (int r = 0; r < int'(M); r++)
      for (int c = 0; c < int'(M); c++) begin
        am[r][c] = 0;
        bm[r][c] = 0;
      end
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst arr_clr", 32'(arr_clr), 32'(0));
    check("rst arr_en", 32'(arr_en), 32'(0));
    check("rst x_feed[0]", x_feed[0], 32'(0));
    check("rst y_feed[5]", y_feed[5], 32'(0));
`ifdef FEEDER_RUN_CNT_EN
    check("rst run_count", run_count, 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // A = identity (1.0 in Q10), B[r][c] = (6r+c)*1024; plus dropped out-of-range writes.
    for (int r = 0; r < int'(M); r++)
      for (int c = 0; c < int'(M); c++) begin
        write_elem(1'b0, r, c, (r == c) ? 1024 : 0);
        write_elem(1'b1, r, c, (r * 6 + c) * 1024);
      end
    write_elem(1'b0, 6, 0, 777);
    write_elem(1'b1, 1, 7, 777);
    run(1'b0, done_at, en_cnt, clr_cnt);
    check("identity done_at", done_at, 18);
    check("identity en cycles", en_cnt, 16);
    check("identity clr cycles", clr_cnt, 1);

    // start and a write during FEED must neither restart nor alter storage.
    run(1'b1, done_at, en_cnt, clr_cnt);
    check("inj done_at", done_at, 18);
    check("inj en cycles", en_cnt, 16);
    run(1'b0, done_at, en_cnt, clr_cnt);
    check("post-inj done_at", done_at, 18);

    // Skew: A[i][j] = 100i+j, B = 0.
    for (int r = 0; r < int'(M); r++)
      for (int c = 0; c < int'(M); c++) begin
        write_elem(1'b0, r, c, 100 * r + c);
        write_elem(1'b1, r, c, 0);
      end
    run(1'b0, done_at, en_cnt, clr_cnt);
    check("skew k7 x_feed[2]", snap7[2], 205);
    check("skew k7 x_feed[5]", snap7[5], 502);
    check("skew k7 x_feed[0]", snap7[0], 0);

    // Same-cycle start + write of A[0][0] = 2048 is included in the run.
    wr_en    = 1'b1;
    wr_sel   = 1'b0;
    wr_row   = '0;
    wr_col   = '0;
    wr_data  = 2048;
    am[0][0] = 2048;
    run(1'b0, done_at, en_cnt, clr_cnt);
    check("same-cycle k0 x_feed[0]", snap0[0], 2048);

    // Reset at k=4 of a run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-rst arr_en k4", 32'(arr_en), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst arr_en", 32'(arr_en), 32'(0));
    check("midrst done", 32'(done), 32'(0));
    check("midrst arr_clr", 32'(arr_clr), 32'(0));
    for (int i = 0; i < int'(M); i++) begin
      check($sformatf("midrst x_feed[%0d]", i), x_feed[i], 32'(0));
      check($sformatf("midrst y_feed[%0d]", i), y_feed[i], 32'(0));
    end
`ifdef FEEDER_RUN_CNT_EN
    check("midrst run_count", run_count, 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, done_at, en_cnt, clr_cnt);
    check("post-rst done_at", done_at, 18);
    run(1'b0, done_at, en_cnt, clr_cnt);
    run(1'b0, done_at, en_cnt, clr_cnt);
`ifdef FEEDER_RUN_CNT_EN
    check("run_count after 3 runs", run_count, 32'(3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
